// File: rtl/hyperbus_wb_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : hyperbus_wb_bridge_if
// Brief    : Wishbone slave bus plus HyperBus controller handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface hyperbus_wb_bridge_if #(
    parameter int ADDR_LENGTH = 32
);
    logic [31:0]            wb_adr_i;
    logic [31:0]            wb_dat_i;
    logic [3:0]             wb_sel_i;
    logic                   wb_we_i;
    logic                   wb_cyc_i;
    logic                   wb_stb_i;
    logic [31:0]            wb_dat_o;
    logic                   wb_ack_o;
    logic                   wb_err_o;
    logic [ADDR_LENGTH-1:0] hb_adr_o;
    logic [15:0]            hb_dat_o;
    logic [2:0]             hb_mask_o;
    logic [15:0]            hb_dat_i;
    logic                   hb_ready_i;
    logic                   hb_valid_i;
    logic                   hb_reg_space_o;
    logic                   hb_wrq_o;
    logic                   hb_rrq_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
               hb_dat_i, hb_ready_i, hb_valid_i,
        output wb_dat_o, wb_ack_o, wb_err_o, hb_adr_o, hb_dat_o, hb_mask_o,
               hb_reg_space_o, hb_wrq_o, hb_rrq_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
               hb_dat_i, hb_ready_i, hb_valid_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, hb_adr_o, hb_dat_o, hb_mask_o,
               hb_reg_space_o, hb_wrq_o, hb_rrq_o
    );
endinterface
`default_nettype wire

// File: rtl/hyperbus_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : hyperbus_wb_bridge
// Brief    : Wishbone B4 classic 32-bit slave turning each access into one
//            two-word HyperBus transaction. Optional macro HBUS_WB_TIMEOUT_EN
//            turns a read timeout into a wb_err_o pulse instead of an ack.
// Revision : 1.0 - initial release
// ============================================================================
module hyperbus_wb_bridge #(
    parameter int ADDR_LENGTH    = 32,
    parameter int REG_SPACE_BIT  = 31,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic           clk,
    input  wire logic           rstn,
    hyperbus_wb_bridge_if.slave bus
);
    localparam int               c_TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0]  c_TIMEOUT = c_TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_WR0    = 3'd2,
        S_WR1    = 3'd3,
        S_WR_END = 3'd4,
        S_ACK    = 3'd5,
        S_GAP    = 3'd6
    } state_t;

    state_t            r_state;
    logic [c_TW-1:0]   r_timer;
    logic              r_rd_half;
    logic [15:0]       r_rd_word0;
    logic [15:0]       r_wr_word1;
    logic [2:0]        r_mask1;
`ifdef HBUS_WB_TIMEOUT_EN
    logic              r_timed_out;
`endif

    logic [31:0] w_byte_adr;
    logic [31:0] w_word_adr;
    logic [15:0] w_wr_word0;
    logic [15:0] w_wr_word1;
    logic [2:0]  w_mask0;
    logic [2:0]  w_mask1;
    logic        w_req;

    always_comb begin
        w_byte_adr                = bus.wb_adr_i;
        w_byte_adr[REG_SPACE_BIT] = 1'b0;
        w_byte_adr[1:0]           = 2'b00;
    end

    assign w_word_adr = w_byte_adr >> 1;
    // HyperBus is big-endian within a word: lower WB byte goes out first.
    assign w_wr_word0 = {bus.wb_dat_i[7:0],   bus.wb_dat_i[15:8]};
    assign w_wr_word1 = {bus.wb_dat_i[23:16], bus.wb_dat_i[31:24]};
    assign w_mask0    = {1'b0, ~bus.wb_sel_i[0], ~bus.wb_sel_i[1]};
    assign w_mask1    = {1'b0, ~bus.wb_sel_i[2], ~bus.wb_sel_i[3]};
    assign w_req      = bus.wb_cyc_i & bus.wb_stb_i;

`ifndef HBUS_WB_TIMEOUT_EN
    assign bus.wb_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state            <= S_IDLE;
            r_timer            <= '0;
            r_rd_half          <= 1'b0;
            r_rd_word0         <= '0;
            r_wr_word1         <= '0;
            r_mask1            <= '0;
            bus.wb_dat_o       <= '0;
            bus.wb_ack_o       <= 1'b0;
            bus.hb_adr_o       <= '0;
            bus.hb_dat_o       <= '0;
            bus.hb_mask_o      <= '0;
            bus.hb_reg_space_o <= 1'b0;
            bus.hb_wrq_o       <= 1'b0;
            bus.hb_rrq_o       <= 1'b0;
`ifdef HBUS_WB_TIMEOUT_EN
            r_timed_out        <= 1'b0;
            bus.wb_err_o       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_timer   <= '0;
                    r_rd_half <= 1'b0;
`ifdef HBUS_WB_TIMEOUT_EN
                    r_timed_out <= 1'b0;
`endif
                    if (w_req) begin
                        bus.hb_adr_o       <= ADDR_LENGTH'(w_word_adr);
                        bus.hb_reg_space_o <= bus.wb_adr_i[REG_SPACE_BIT];
                        if (bus.wb_we_i) begin
                            bus.hb_dat_o  <= w_wr_word0;
                            bus.hb_mask_o <= w_mask0;
                            r_wr_word1    <= w_wr_word1;
                            r_mask1       <= w_mask1;
                            bus.hb_wrq_o  <= 1'b1;
                            r_state       <= S_WR0;
                        end else begin
                            bus.hb_rrq_o  <= 1'b1;
                            r_state       <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    // A valid always beats the timeout; the timer saturates so a
                    // late first word still leads to an abort on the next cycle.
                    if (bus.hb_valid_i && r_rd_half) begin
                        bus.wb_dat_o <= {bus.hb_dat_i[7:0], bus.hb_dat_i[15:8],
                                         r_rd_word0[7:0],   r_rd_word0[15:8]};
                        bus.hb_rrq_o <= 1'b0;
                        r_state      <= S_ACK;
                    end else if (bus.hb_valid_i) begin
                        r_rd_word0 <= bus.hb_dat_i;
                        r_rd_half  <= 1'b1;
                        r_timer    <= (r_timer == c_TIMEOUT) ? r_timer : r_timer + 1'b1;
                    end else if (r_timer == c_TIMEOUT) begin
                        bus.hb_rrq_o <= 1'b0;
                        bus.wb_dat_o <= '0;
`ifdef HBUS_WB_TIMEOUT_EN
                        r_timed_out  <= 1'b1;
`endif
                        r_state      <= S_ACK;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_WR0: begin
                    if (bus.hb_ready_i) begin
                        bus.hb_dat_o  <= r_wr_word1;
                        bus.hb_mask_o <= r_mask1;
                        r_state       <= S_WR1;
                    end
                end
                S_WR1: begin
                    bus.hb_wrq_o <= 1'b0;
                    r_state      <= S_WR_END;
                end
                S_WR_END: begin
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    // Response lands in GAP, keeping it two cycles behind the last word.
`ifdef HBUS_WB_TIMEOUT_EN
                    if (r_timed_out) begin
                        bus.wb_err_o <= w_req;
                    end else begin
                        bus.wb_ack_o <= w_req;
                    end
`else
                    bus.wb_ack_o <= w_req;
`endif
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    bus.wb_ack_o <= 1'b0;
`ifdef HBUS_WB_TIMEOUT_EN
                    bus.wb_err_o <= 1'b0;
`endif
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_hyperbus_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_hyperbus_wb_bridge
// Brief    : Directed self-checking bench for hyperbus_wb_bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hyperbus_wb_bridge;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    hyperbus_wb_bridge_if #(.ADDR_LENGTH(32)) bus ();

    hyperbus_wb_bridge #(
        .ADDR_LENGTH   (32),
        .REG_SPACE_BIT (31),
        .TIMEOUT_CYCLES(255)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

`ifdef HBUS_WB_TIMEOUT_EN
    localparam logic c_TO_ERR = 1'b1;
`else
    localparam logic c_TO_ERR = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wb_start(input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic we);
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        bus.wb_we_i  = we;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
    endtask

    task automatic wait_resp(input string tag, input logic exp_err, input logic chk_dat,
                             input logic [31:0] exp_dat, input int exp_lat);
        int n = 0;
        while (!(bus.wb_ack_o || bus.wb_err_o) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_ack"}, 32'(bus.wb_ack_o), 32'(!exp_err));
        check({tag, "_err"}, 32'(bus.wb_err_o), 32'(exp_err));
        if (chk_dat) check({tag, "_dat"}, bus.wb_dat_o, exp_dat);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        @(negedge clk);
        check({tag, "_once"}, 32'({bus.wb_ack_o, bus.wb_err_o}), 32'd0);
    endtask

    initial begin
        int cnt;
        int gap;
        int k;
        bus.wb_adr_i   = '0;
        bus.wb_dat_i   = '0;
        bus.wb_sel_i   = '0;
        bus.wb_we_i    = 1'b0;
        bus.wb_cyc_i   = 1'b0;
        bus.wb_stb_i   = 1'b0;
        bus.hb_dat_i   = '0;
        bus.hb_ready_i = 1'b0;
        bus.hb_valid_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ack",  32'(bus.wb_ack_o), 32'd0);
        check("rst_err",  32'(bus.wb_err_o), 32'd0);
        check("rst_rrq",  32'(bus.hb_rrq_o), 32'd0);
        check("rst_wrq",  32'(bus.hb_wrq_o), 32'd0);
        check("rst_adr",  bus.hb_adr_o, 32'd0);
        check("rst_rdat", bus.wb_dat_o, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Write, full select, ready after 10 cycles
        wb_start(32'h0000_0100, 32'hAABB_CCDD, 4'hF, 1'b1);
        @(negedge clk);
        check("w1_wrq",   32'(bus.hb_wrq_o), 32'd1);
        check("w1_rrq",   32'(bus.hb_rrq_o), 32'd0);
        check("w1_adr",   bus.hb_adr_o, 32'h80);
        check("w1_rs",    32'(bus.hb_reg_space_o), 32'd0);
        check("w1_word0", 32'(bus.hb_dat_o), 32'hDDCC);
        check("w1_mask0", 32'(bus.hb_mask_o), 32'd0);
        repeat (9) @(negedge clk);
        check("w1_hold",  32'(bus.hb_dat_o), 32'hDDCC);
        check("w1_noack", 32'(bus.wb_ack_o), 32'd0);
        bus.hb_ready_i = 1'b1;
        @(negedge clk);
        check("w1_word1", 32'(bus.hb_dat_o), 32'hBBAA);
        check("w1_mask1", 32'(bus.hb_mask_o), 32'd0);
        check("w1_wrq1",  32'(bus.hb_wrq_o), 32'd1);
        @(negedge clk);
        check("w1_wrq_drop", 32'(bus.hb_wrq_o), 32'd0);
        bus.hb_ready_i = 1'b0;
        wait_resp("w1", 1'b0, 1'b0, 32'd0, 2);

        // Write with partial byte select
        wb_start(32'h0000_0200, 32'h1122_3344, 4'b0101, 1'b1);
        @(negedge clk);
        check("w2_adr",   bus.hb_adr_o, 32'h100);
        check("w2_word0", 32'(bus.hb_dat_o), 32'h4433);
        check("w2_mask0", 32'(bus.hb_mask_o), 32'b001);
        bus.hb_ready_i = 1'b1;
        @(negedge clk);
        check("w2_word1", 32'(bus.hb_dat_o), 32'h2211);
        check("w2_mask1", 32'(bus.hb_mask_o), 32'b001);
        @(negedge clk);
        check("w2_wrq_drop", 32'(bus.hb_wrq_o), 32'd0);
        bus.hb_ready_i = 1'b0;
        wait_resp("w2", 1'b0, 1'b0, 32'd0, 2);

        // Register-space read with a 3-cycle gap between words
        wb_start(32'h8000_0004, 32'd0, 4'hF, 1'b0);
        @(negedge clk);
        check("r1_rrq", 32'(bus.hb_rrq_o), 32'd1);
        check("r1_wrq", 32'(bus.hb_wrq_o), 32'd0);
        check("r1_rs",  32'(bus.hb_reg_space_o), 32'd1);
        check("r1_adr", bus.hb_adr_o, 32'd2);
        bus.hb_dat_i   = 16'h1234;
        bus.hb_valid_i = 1'b1;
        @(negedge clk);
        bus.hb_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("r1_rrq_mid", 32'(bus.hb_rrq_o), 32'd1);
        bus.hb_dat_i   = 16'h5678;
        bus.hb_valid_i = 1'b1;
        @(negedge clk);
        check("r1_rrq_drop", 32'(bus.hb_rrq_o), 32'd0);
        check("r1_early",    32'(bus.wb_ack_o), 32'd0);
        bus.hb_dat_i = 16'hFFFF;
        @(negedge clk);
        bus.hb_valid_i = 1'b0;
        wait_resp("r1", 1'b0, 1'b1, 32'h7856_3412, 0);

        // Read with no data returned
        wb_start(32'h0000_0040, 32'd0, 4'hF, 1'b0);
        @(negedge clk);
        cnt = 0;
        while (bus.hb_rrq_o && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        check("to_rrq_cycles", 32'(cnt), 32'd256);
        check("to_early", 32'({bus.wb_ack_o, bus.wb_err_o}), 32'd0);
        wait_resp("to", c_TO_ERR, 1'b1, 32'd0, 1);

        // Back-to-back read then write
        wb_start(32'h0000_0010, 32'd0, 4'hF, 1'b0);
        @(negedge clk);
        bus.hb_dat_i   = 16'h0102;
        bus.hb_valid_i = 1'b1;
        @(negedge clk);
        bus.hb_dat_i   = 16'h0304;
        @(negedge clk);
        bus.hb_valid_i = 1'b0;
        gap = 0;
        if (!bus.hb_rrq_o && !bus.hb_wrq_o) gap++;
        k = 0;
        while (!bus.wb_ack_o && k < 20) begin
            @(negedge clk);
            k++;
            if (!bus.hb_rrq_o && !bus.hb_wrq_o) gap++;
        end
        check("b2b_rd_ack", 32'(bus.wb_ack_o), 32'd1);
        check("b2b_rd_dat", bus.wb_dat_o, 32'h0403_0201);
        wb_start(32'h0000_0300, 32'hCAFE_F00D, 4'hF, 1'b1);
        @(negedge clk);
        check("b2b_rd_once", 32'(bus.wb_ack_o), 32'd0);
        if (!bus.hb_rrq_o && !bus.hb_wrq_o) gap++;
        k = 0;
        while (!bus.hb_wrq_o && k < 20) begin
            @(negedge clk);
            k++;
            if (!bus.hb_rrq_o && !bus.hb_wrq_o) gap++;
        end
        check("b2b_gap_ge2", 32'(gap >= 2), 32'd1);
        check("b2b_word0", 32'(bus.hb_dat_o), 32'h0DF0);
        bus.hb_ready_i = 1'b1;
        @(negedge clk);
        check("b2b_word1", 32'(bus.hb_dat_o), 32'hFECA);
        @(negedge clk);
        bus.hb_ready_i = 1'b0;
        wait_resp("b2b_wr", 1'b0, 1'b0, 32'd0, 2);

        // Reset asserted while the second write word is exposed
        wb_start(32'h0000_0400, 32'h5566_7788, 4'hF, 1'b1);
        @(negedge clk);
        bus.hb_ready_i = 1'b1;
        @(negedge clk);
        check("rs_wrq_pre", 32'(bus.hb_wrq_o), 32'd1);
        rstn = 1'b0;
        #1;
        check("rs_wrq", 32'(bus.hb_wrq_o), 32'd0);
        check("rs_ack", 32'(bus.wb_ack_o), 32'd0);
        check("rs_dat", 32'(bus.hb_dat_o), 32'd0);
        bus.hb_ready_i = 1'b0;
        bus.wb_cyc_i   = 1'b0;
        bus.wb_stb_i   = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rs_no_ack", 32'(bus.wb_ack_o), 32'd0);

        // Normal read after reset release
        wb_start(32'h0000_0020, 32'd0, 4'hF, 1'b0);
        @(negedge clk);
        check("pr_rrq", 32'(bus.hb_rrq_o), 32'd1);
        check("pr_adr", bus.hb_adr_o, 32'h10);
        bus.hb_dat_i   = 16'hABCD;
        bus.hb_valid_i = 1'b1;
        @(negedge clk);
        bus.hb_dat_i   = 16'hEF01;
        @(negedge clk);
        bus.hb_valid_i = 1'b0;
        check("pr_rrq_drop", 32'(bus.hb_rrq_o), 32'd0);
        wait_resp("pr", 1'b0, 1'b1, 32'h01EF_CDAB, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
